// File: rtl/shift_add_pkg.sv
// ============================================================================
// Module      : shift_add_pkg
// Description : Shared widths, FSM state type and shift-code decoding for the
//               shift_add multiplier and the shift_code_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_add_pkg;

    function automatic int code_w(input int bits);
        return $clog2(bits + 2) + 1;
    endfunction

    function automatic int res_w(input int bits);
        return bits + 3;
    endfunction

    function automatic int exp_w(input int bits);
        return (bits < 1) ? 1 : $clog2(bits + 1);
    endfunction

    localparam int C_DEFAULT_BITS   = 17;
    localparam int C_DEFAULT_CODE_W = code_w(C_DEFAULT_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    typedef logic signed [C_DEFAULT_CODE_W-1:0] shift_code_t;

    typedef struct packed {
        logic                        active;
        logic                        negate;
        logic [C_DEFAULT_CODE_W-1:0] shamt;
    } shift_op_t;

    // Code k != 0 means a term of magnitude x << (|k|-1), subtracted when k < 0.
    function automatic shift_op_t decode_shift_code(input shift_code_t code);
        shift_op_t                   op;
        logic [C_DEFAULT_CODE_W-1:0] mag;
        mag       = code[C_DEFAULT_CODE_W-1] ? (~code + 1'b1) : code;
        op.active = (code != '0);
        op.negate = code[C_DEFAULT_CODE_W-1];
        op.shamt  = op.active ? (mag - 1'b1) : '0;
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nearest_pow2_step.sv
// ============================================================================
// Module      : nearest_pow2_step
// Description : One step of the nearest-power-of-two scan: keeps candidate
//               exponent only if strictly closer to |residual| than best.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nearest_pow2_step #(
    parameter int RES_W = 20,
    parameter int EXP_W = 5
) (
    input  logic signed [RES_W-1:0] residual,
    input  logic        [EXP_W-1:0] cand,
    input  logic        [EXP_W-1:0] best,
    output logic        [EXP_W-1:0] best_next
);

    localparam logic [RES_W-1:0] C_ONE = RES_W'(1);

    logic        [RES_W-1:0] w_abs_r;
    logic        [RES_W-1:0] w_pow_cand;
    logic        [RES_W-1:0] w_pow_best;
    logic signed [RES_W-1:0] w_diff_cand;
    logic signed [RES_W-1:0] w_diff_best;
    logic        [RES_W-1:0] w_dist_cand;
    logic        [RES_W-1:0] w_dist_best;

    always_comb begin
        w_abs_r     = residual[RES_W-1] ? (~residual + 1'b1) : residual;
        w_pow_cand  = C_ONE << cand;
        w_pow_best  = C_ONE << best;
        w_diff_cand = $signed(w_abs_r - w_pow_cand);
        w_diff_best = $signed(w_abs_r - w_pow_best);
        w_dist_cand = w_diff_cand[RES_W-1] ? (~w_diff_cand + 1'b1) : w_diff_cand;
        w_dist_best = w_diff_best[RES_W-1] ? (~w_diff_best + 1'b1) : w_diff_best;
        // Strict compare: on a tie the earlier (larger) exponent survives.
        best_next   = (w_dist_cand < w_dist_best) ? cand : best;
    end

endmodule

`default_nettype wire

// File: rtl/shift_code_encoder.sv
// ============================================================================
// Module      : shift_code_encoder
// Description : Greedy signed power-of-two decomposition of a weight into
//               DEPTH shift codes plus remainder. Optional macro
//               SHIFT_ENC_EARLY_EXIT_EN stops once the residual reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_code_encoder
    import shift_add_pkg::*;
#(
    parameter  int W_BITS = 16,
    parameter  int BITS   = 17,
    parameter  int DEPTH  = 2,
    localparam int CODE_W = code_w(BITS),
    localparam int RES_W  = res_w(BITS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W_BITS-1:0]         weight,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DEPTH*CODE_W-1:0]   codes,
    output logic [RES_W-1:0]          remainder,
    output logic                      complex
);

    localparam int                      EXP_W       = exp_w(BITS);
    localparam int                      T_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [EXP_W-1:0]        C_TOP_EXP   = EXP_W'(BITS);
    localparam logic [T_W-1:0]          C_LAST_TERM = T_W'(DEPTH - 1);
    localparam logic signed [RES_W-1:0] C_ONE       = RES_W'(1);

    enc_state_t               r_state;
    logic signed [RES_W-1:0]  r_resid;
    logic [T_W-1:0]           r_term;
    logic [EXP_W-1:0]         r_cand;
    logic [EXP_W-1:0]         r_best;
    logic [DEPTH*CODE_W-1:0]  r_codes;

    enc_state_t               w_state_next;
    logic signed [RES_W-1:0]  w_resid_next;
    logic [T_W-1:0]           w_term_next;
    logic [EXP_W-1:0]         w_cand_next;
    logic [EXP_W-1:0]         w_best_next;
    logic [DEPTH*CODE_W-1:0]  w_codes_next;

    logic [EXP_W-1:0]         w_best_upd;
    logic signed [RES_W-1:0]  w_weight_ext;
    logic signed [RES_W-1:0]  w_pow_best;
    logic signed [RES_W-1:0]  w_resid_commit;
    logic signed [CODE_W-1:0] w_code_mag;
    logic signed [CODE_W-1:0] w_code;

    nearest_pow2_step #(
        .RES_W (RES_W),
        .EXP_W (EXP_W)
    ) u_step (
        .residual  (r_resid),
        .cand      (r_cand),
        .best      (r_best),
        .best_next (w_best_upd)
    );

    assign w_weight_ext = {{(RES_W-W_BITS){weight[W_BITS-1]}}, weight};

    // Term value for the current commit, using this cycle's compare result.
    always_comb begin
        w_pow_best     = C_ONE << w_best_upd;
        w_code_mag     = CODE_W'(w_best_upd) + CODE_W'(1);
        w_code         = '0;
        w_resid_commit = r_resid;
        if (r_resid != '0) begin
            if (r_resid[RES_W-1]) begin
                w_code         = -w_code_mag;
                w_resid_commit = r_resid + w_pow_best;
            end else begin
                w_code         = w_code_mag;
                w_resid_commit = r_resid - w_pow_best;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_resid_next = r_resid;
        w_term_next  = r_term;
        w_cand_next  = r_cand;
        w_best_next  = r_best;
        w_codes_next = r_codes;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_SCAN;
                    w_resid_next = w_weight_ext;
                    w_term_next  = '0;
                    w_cand_next  = C_TOP_EXP;
                    w_best_next  = C_TOP_EXP;
                    w_codes_next = '0;
                end
            end

            ST_SCAN: begin
                w_best_next = w_best_upd;
                if (r_cand == '0) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (r_term == T_W'(k)) begin
                            w_codes_next[k*CODE_W +: CODE_W] = w_code;
                        end
                    end
                    w_resid_next = w_resid_commit;
                    w_term_next  = r_term + 1'b1;
                    w_cand_next  = C_TOP_EXP;
                    w_best_next  = C_TOP_EXP;
                    if (r_term == C_LAST_TERM) begin
                        w_state_next = ST_DONE;
                    end
`ifdef SHIFT_ENC_EARLY_EXIT_EN
                    // Untouched codes were cleared on accept, so they already read 0.
                    if (w_resid_commit == '0) begin
                        w_state_next = ST_DONE;
                    end
`endif
                end else begin
                    w_cand_next = r_cand - 1'b1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_resid <= '0;
            r_term  <= '0;
            r_cand  <= '0;
            r_best  <= '0;
            r_codes <= '0;
        end else begin
            r_state <= w_state_next;
            r_resid <= w_resid_next;
            r_term  <= w_term_next;
            r_cand  <= w_cand_next;
            r_best  <= w_best_next;
            r_codes <= w_codes_next;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign codes     = r_codes;
    assign remainder = r_resid;
    assign complex   = (r_resid != '0);

endmodule

`default_nettype wire

// File: tb/tb_shift_code_encoder.sv
// ============================================================================
// Module      : tb_shift_code_encoder
// Description : Scoreboard bench for shift_code_encoder (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_code_encoder;

    localparam int W_BITS   = 16;
    localparam int BITS     = 17;
    localparam int DEPTH    = 2;
    localparam int CODE_W   = 6;
    localparam int RES_W    = 20;
    localparam int SCAN_LEN = BITS + 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [W_BITS-1:0]       weight = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [DEPTH*CODE_W-1:0] codes;
    logic [RES_W-1:0]        remainder;
    logic                    complex;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DEPTH*CODE_W-1:0] codes;
        logic [RES_W-1:0]        rem;
        logic                    cpx;
        int                      lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    shift_code_encoder #(
        .W_BITS (W_BITS),
        .BITS   (BITS),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weight    (weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codes     (codes),
        .remainder (remainder),
        .complex   (complex)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_for(input int terms);
`ifdef SHIFT_ENC_EARLY_EXIT_EN
        return terms * SCAN_LEN;
`else
        return DEPTH * SCAN_LEN;
`endif
    endfunction

    // Hand-derived expectation: term codes, remainder, terms until residual is 0.
    function automatic exp_t mk(input int c0, input int c1, input int rem, input int terms);
        exp_t e;
        e.codes = {c1[CODE_W-1:0], c0[CODE_W-1:0]};
        e.rem   = rem[RES_W-1:0];
        e.cpx   = (rem != 0);
        e.lat   = lat_for(terms);
        return e;
    endfunction

    // Reference: ascending exponent scan, '<=' so ties go to the larger power.
    function automatic exp_t model(input int w);
        exp_t e;
        int   r;
        int   used;
        int   code;
        int   a;
        int   best;
        int   bestd;
        int   d;
        r       = w;
        used    = DEPTH;
        e.codes = '0;
        for (int t = 0; t < DEPTH; t++) begin
            code = 0;
            if (r != 0) begin
                a     = (r < 0) ? -r : r;
                best  = 0;
                bestd = (a > 1) ? a - 1 : 1 - a;
                for (int k = 1; k <= BITS; k++) begin
                    d = (a > (1 << k)) ? a - (1 << k) : (1 << k) - a;
                    if (d <= bestd) begin
                        best  = k;
                        bestd = d;
                    end
                end
                code = (r > 0) ? best + 1 : -(best + 1);
                r    = (r > 0) ? r - (1 << best) : r + (1 << best);
            end
            e.codes[t*CODE_W +: CODE_W] = code[CODE_W-1:0];
            if (r == 0 && used == DEPTH) used = t + 1;
        end
        e.rem = r[RES_W-1:0];
        e.cpx = (r != 0);
        e.lat = lat_for(used);
        return e;
    endfunction

    task automatic run_weight(input logic [W_BITS-1:0] w, input exp_t e,
                              input int hold, input bit ready_early);
        int   lat;
        exp_t got;
        sb.push_back(e);
        @(negedge clk);
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        weight   = w;
        @(posedge clk);
        #1;
        out_ready = ready_early;
        lat = 0;
        while (lat < 200) begin
            in_valid = 1'(($urandom_range(0, 1)));
            weight   = W_BITS'($urandom);
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        got = sb.pop_front();
        check("latency",   64'(lat),              64'(got.lat));
        check("codes",     64'(codes),            64'(got.codes));
        check("remainder", 64'(remainder),        64'(got.rem));
        check("complex",   {63'd0, complex},      {63'd0, got.cpx});
        check("busy_ready",{63'd0, in_ready},     64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1;
            weight   = W_BITS'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_ready", {63'd0, in_ready},  64'd0);
            check("hold_codes", 64'(codes),         64'(got.codes));
            check("hold_rem",   64'(remainder),     64'(got.rem));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_valid", {63'd0, out_valid}, 64'd0);
        check("post_ready", {63'd0, in_ready},  64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W_BITS-1:0] rw;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ready", {63'd0, in_ready},  64'd1);
        check("rst_codes", 64'(codes),         64'd0);
        check("rst_rem",   64'(remainder),     64'd0);
        check("rst_cpx",   {63'd0, complex},   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_weight(16'd1,      mk( 1,  0,  0, 1), 0, 1'b0);
        run_weight(16'd7,      mk( 4, -1,  0, 2), 0, 1'b1);
        run_weight(-16'sd6,    mk(-4,  2,  0, 2), 0, 1'b0);
        run_weight(16'd11,     mk( 4,  3, -1, 2), 0, 1'b0);
        run_weight(16'h8000,   mk(-16, 0,  0, 1), 0, 1'b1);
        run_weight(16'd0,      mk( 0,  0,  0, 1), 0, 1'b0);

        // Backpressure in DONE with in_valid asserted throughout.
        run_weight(16'd100,    model(100), 10, 1'b0);
        run_weight(16'h7FFF,   model(32767), 0, 1'b0);

        // Reset in the middle of a scan.
        @(negedge clk);
        in_valid = 1'b1;
        weight   = 16'd1234;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready},  64'd1);
        check("mid_rst_codes", 64'(codes),         64'd0);
        check("mid_rst_rem",   64'(remainder),     64'd0);
        check("mid_rst_cpx",   {63'd0, complex},   64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_weight(-16'sd6,    mk(-4,  2,  0, 2), 0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            rw = W_BITS'($urandom);
            run_weight(rw, model(int'($signed(rw))), 0, 1'(n % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_code_encoder.md
Name: shift_code_encoder

Overview:
- Runtime encoder producing the shift-add term codes that the constant shift_add multiplier consumes.
- Takes a signed weight over a valid/ready handshake and greedily decomposes it into up to DEPTH signed power-of-two terms. Each term is found by a sequential nearest-power scan.
- Emits packed signed shift codes, the leftover remainder, and a "complex" flag.
- Used by the 2D-conv weight loader to decide, per weight, between the shift-add path and the multiplier fallback.

Parameters:
- W_BITS, 16: weight input width (signed).
- BITS, 17: highest exponent searched; candidate exponents are BITS down to 0.
- DEPTH, 2: number of shift terms emitted.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous active-low reset.
- in_valid  in  1  weight valid.
- in_ready  out  1  encoder can accept a weight.
- weight  in  W_BITS  signed weight to encode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- codes  out  DEPTH*CODE_W  term i in bits [i*CODE_W +: CODE_W], term 0 first. Each code is signed: 0 = no term, +k = add (x<<(k-1)), -k = subtract (x<<(k-1)).
- remainder  out  RES_W  signed residual after DEPTH terms.
- complex  out  1  remainder != 0.

Behaviour:
- Widths:
  - CODE_W = $clog2(BITS+2)+1.
  - RES_W = BITS+3.
  - All residual arithmetic is signed RES_W; weight is sign-extended on accept. No overflow is possible.
- FSM states IDLE, SCAN, DONE.
- Reset: state=IDLE, in_ready=1, out_valid=0, codes=0, remainder=0, complex=0, all internal registers 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch residual r=weight, term index t=0, candidate i=BITS, best n=BITS. Go to SCAN.
- SCAN (in_ready=0), one candidate per cycle:
  - If |(|r|-2^i)| < |(|r|-2^n)| (strict), set n=i. Ties keep the larger exponent.
  - When i==0 the term commits with the comparison of that cycle included:
    - code[t] = (r==0) ? 0 : (r>=0 ? n+1 : -(n+1)).
    - If r!=0: r = r>=0 ? r-2^n : r+2^n.
    - Then t++, i=BITS, n=BITS.
  - Otherwise i--.
  - After term DEPTH-1 commits, go to DONE.
- DONE:
  - out_valid=1; codes, remainder=r and complex stay stable until out_ready.
  - On out_ready, go to IDLE: out_valid=0 and in_ready=1 on the next cycle.
  - No accept in the same cycle as output handshake.
- Latency: out_valid rises exactly DEPTH*(BITS+1) cycles after the accept edge (36 with defaults). Throughput is one weight per DEPTH*(BITS+1)+2 cycles minimum.
- Weight 0: all codes 0, remainder 0, complex 0, same latency.
- Most negative weight (-2^(W_BITS-1)) must encode correctly; absolute values are taken in RES_W.
- in_valid while busy is ignored (in_ready=0); weight need not stay stable after accept.
- out_ready held high before DONE has no effect.
- rst_n low mid-SCAN or in DONE: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro SHIFT_ENC_EARLY_EXIT_EN.
- Defined: when a commit leaves r==0, remaining codes are written 0 and the FSM goes directly to DONE. Latency becomes (terms actually used)*(BITS+1), minimum BITS+1 (weight 0 exits after term 0).
- Undefined: fixed latency as above. Codes, remainder and complex values are identical in both builds.

Decomposition:
- Package shift_add_pkg holds:
  - CODE_W and RES_W as functions of BITS;
  - the state enum;
  - a shift_code_t typedef;
  - the function mapping signed code to shift amount/sign, shared with shift_add.
- One sub-module, nearest_pow2_step: combinational compare of candidate i versus best n for a residual, returning updated n. The encoder instantiates it once.

Test Plan:
- Weight 1 -> codes[0]=+1, codes[1]=0, remainder 0, complex 0, out_valid 36 cycles after accept.
- Weight 7 -> codes {+4,-1} (8-1), remainder 0. Weight -6 -> codes {-4,+2} (tie 4/8 picks 8), remainder 0.
- Weight 11 -> codes {+4,+3} (tie 2/4 picks 4), remainder -1, complex 1. Weight -32768 -> codes {-16,0}, remainder 0.
- Backpressure: out_ready low 10 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored. Release -> in_ready 1 next cycle, next weight accepted.
- Reset asserted at cycle 20 of SCAN -> outputs at reset values immediately. The next weight after release encodes correctly with full latency.
- With SHIFT_ENC_EARLY_EXIT_EN: weight 1 -> out_valid after 18 cycles; weight 7 -> after 36; weight 0 -> after 18; codes identical to the non-macro build.
